// File: rtl/alu_vector_gen.sv
// alu_vector_gen
//   Sweeps every {select, mode, carry-in, A, B} combination into an attached
//   74181-style ALU, waits SETTLE cycles, samples the result and streams each
//   record as a 19-bit vector over a valid/ready handshake.
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-low reset
//   start           begin a sweep (honoured only in IDLE or DONE)
//   alu_s/m/ci/a/b  ALU inputs, driven straight from the index register
//   alu_y           ALU result (combinational from the alu_* outputs)
//   vec_valid/ready/data  vector stream {1'b0, s, m, ci, a, b, y}
//   vec_count       vectors transferred in the current sweep
//   busy, done      sweep in progress / sweep finished
module alu_vector_gen #(
  parameter int SETTLE     = 1,     // 1..15
  parameter int LAST_INDEX = 16383  // final sweep index
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  alu_s,
  output logic        alu_m,
  output logic        alu_ci,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_y,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [18:0] vec_data,
  output logic [14:0] vec_count,
  output logic        busy,
  output logic        done
);

  localparam logic [13:0] LAST   = 14'(LAST_INDEX);
  localparam logic [3:0]  SET_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, FIN} state_t;

  state_t      state, state_nx;
  logic [13:0] idx;
  logic [3:0]  settle_cnt;
  logic        settled;
  logic        xfer;
  logic        at_last;

  assign settled = (state == DRIVE) && (settle_cnt == SET_M1);
  assign xfer    = (state == EMIT) && vec_ready;
  assign at_last = (idx == LAST);

  // idx is itself the register feeding the ALU, so the ALU sees a new index
  // on the same edge that enters DRIVE.
  assign {alu_s, alu_m, alu_ci, alu_a, alu_b} = idx;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)   state_nx = DRIVE;
      DRIVE:   if (settled) state_nx = EMIT;
      EMIT:    if (vec_ready) state_nx = at_last ? FIN : DRIVE;
      FIN:     if (start)   state_nx = DRIVE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    vec_valid = (state == EMIT);
    busy      = (state == DRIVE) || (state == EMIT);
    done      = (state == FIN);
  end

  // Datapath: index, settle counter, captured vector, transfer count.
  // A reset mid-handshake simply drops the pending vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx        <= '0;
      settle_cnt <= '0;
      vec_data   <= '0;
      vec_count  <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= '0;
            vec_count  <= '0;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settled) vec_data <= {1'b0, idx, alu_y};
        end
        EMIT: begin
          if (xfer) begin
            vec_count <= vec_count + 15'd1;
            // No wrap: the final index stays put and the FSM parks in FIN.
            if (!at_last) begin
              idx        <= idx + 14'd1;
              settle_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_gen.sv
// Bench for alu_vector_gen. Four instances share clk and reset:
//   f: SETTLE=1, full sweep, combinational reference ALU
//   b: SETTLE=3, LAST_INDEX=63, 2-cycle-delayed ALU, random backpressure
//   q: SETTLE=1, LAST_INDEX=63, 2-cycle-delayed ALU (sampling too early)
//   r: SETTLE=1, LAST_INDEX=3, restart / ignored-start behaviour
// Expected vectors are queued when a sweep is started and popped on transfer.
module tb_alu_vector_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   nerr = 0;
  int   nchk = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU stand-in: any fixed function of all 14 input bits.
  function automatic logic [3:0] alu_ref(input logic [13:0] v);
    logic [3:0] s, a, b;
    logic       m, ci;
    {s, m, ci, a, b} = v;
    if (m) return (~(a & b)) ^ s;
    else   return a + b + {3'b0, ci} + s;
  endfunction

  function automatic logic [18:0] exp_vec(input logic [13:0] v);
    return {1'b0, v, alu_ref(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance f ----------------
  logic f_start, f_ready, f_m, f_ci, f_valid, f_busy, f_done;
  logic [3:0] f_s, f_a, f_b, f_y;
  logic [18:0] f_data;
  logic [14:0] f_count;
  assign f_y = alu_ref({f_s, f_m, f_ci, f_a, f_b});

  alu_vector_gen #(.SETTLE(1), .LAST_INDEX(16383)) u_f (
    .clk(clk), .reset(rst_n), .start(f_start),
    .alu_s(f_s), .alu_m(f_m), .alu_ci(f_ci), .alu_a(f_a), .alu_b(f_b), .alu_y(f_y),
    .vec_valid(f_valid), .vec_ready(f_ready), .vec_data(f_data),
    .vec_count(f_count), .busy(f_busy), .done(f_done));

  // ---------------- instance b ----------------
  logic b_start, b_ready, b_m, b_ci, b_valid, b_busy, b_done;
  logic [3:0] b_s, b_a, b_b, b_y1, b_y2;
  logic [18:0] b_data;
  logic [14:0] b_count;
  always @(posedge clk) begin
    b_y1 <= alu_ref({b_s, b_m, b_ci, b_a, b_b});
    b_y2 <= b_y1;
  end

  alu_vector_gen #(.SETTLE(3), .LAST_INDEX(63)) u_b (
    .clk(clk), .reset(rst_n), .start(b_start),
    .alu_s(b_s), .alu_m(b_m), .alu_ci(b_ci), .alu_a(b_a), .alu_b(b_b), .alu_y(b_y2),
    .vec_valid(b_valid), .vec_ready(b_ready), .vec_data(b_data),
    .vec_count(b_count), .busy(b_busy), .done(b_done));

  // ---------------- instance q ----------------
  logic q_start, q_ready, q_m, q_ci, q_valid, q_busy, q_done;
  logic [3:0] q_s, q_a, q_b, q_y1, q_y2;
  logic [18:0] q_data;
  logic [14:0] q_count;
  always @(posedge clk) begin
    q_y1 <= alu_ref({q_s, q_m, q_ci, q_a, q_b});
    q_y2 <= q_y1;
  end

  alu_vector_gen #(.SETTLE(1), .LAST_INDEX(63)) u_q (
    .clk(clk), .reset(rst_n), .start(q_start),
    .alu_s(q_s), .alu_m(q_m), .alu_ci(q_ci), .alu_a(q_a), .alu_b(q_b), .alu_y(q_y2),
    .vec_valid(q_valid), .vec_ready(q_ready), .vec_data(q_data),
    .vec_count(q_count), .busy(q_busy), .done(q_done));

  // ---------------- instance r ----------------
  logic r_start, r_ready, r_m, r_ci, r_valid, r_busy, r_done;
  logic [3:0] r_s, r_a, r_b, r_y;
  logic [18:0] r_data;
  logic [14:0] r_count;
  assign r_y = alu_ref({r_s, r_m, r_ci, r_a, r_b});

  alu_vector_gen #(.SETTLE(1), .LAST_INDEX(3)) u_r (
    .clk(clk), .reset(rst_n), .start(r_start),
    .alu_s(r_s), .alu_m(r_m), .alu_ci(r_ci), .alu_a(r_a), .alu_b(r_b), .alu_y(r_y),
    .vec_valid(r_valid), .vec_ready(r_ready), .vec_data(r_data),
    .vec_count(r_count), .busy(r_busy), .done(r_done));

  // ---------------- scoreboards / monitors ----------------
  // A transfer is seen at the negedge before the posedge that completes it.
  logic [18:0] f_q[$], b_q[$], r_q[$];
  int f_x = 0, b_x = 0, q_x = 0, r_x = 0, q_mis = 0;
  logic bd_bad = 1'b0;

  always @(negedge clk) begin
    if (rst_n && f_valid && f_ready) begin
      if (f_q.size() == 0) chk("f_extra_vec", 32'd1, 32'd0);
      else                 chk("f_vec", {13'b0, f_data}, {13'b0, f_q.pop_front()});
      f_x <= f_x + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_valid && b_ready) begin
      if (b_q.size() == 0) chk("b_extra_vec", 32'd1, 32'd0);
      else                 chk("b_vec", {13'b0, b_data}, {13'b0, b_q.pop_front()});
      b_x <= b_x + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && q_valid && q_ready) begin
      if (q_data[3:0] != alu_ref(q_data[17:4])) q_mis <= q_mis + 1;
      q_x <= q_x + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && r_valid && r_ready) begin
      if (r_q.size() == 0) chk("r_extra_vec", 32'd1, 32'd0);
      else                 chk("r_vec", {13'b0, r_data}, {13'b0, r_q.pop_front()});
      r_x <= r_x + 1;
    end
  end

  // Stall stability on b: if the previous negedge saw valid without ready,
  // the vector and the ALU inputs must not have moved.
  logic        b_pv = 1'b0, b_pr = 1'b0;
  logic [18:0] b_pd;
  logic [13:0] b_pa;
  always @(negedge clk) begin
    if (rst_n && b_pv && !b_pr) begin
      chk("b_stall_valid", {31'b0, b_valid}, 32'd1);
      chk("b_stall_data", {13'b0, b_data}, {13'b0, b_pd});
      chk("b_stall_alu", {18'b0, b_s, b_m, b_ci, b_a, b_b}, {18'b0, b_pa});
    end
    b_pv <= b_valid;
    b_pr <= b_ready;
    b_pd <= b_data;
    b_pa <= {b_s, b_m, b_ci, b_a, b_b};
  end

  always @(negedge clk)
    if ((f_busy & f_done) | (b_busy & b_done) | (q_busy & q_done) | (r_busy & r_done))
      bd_bad <= 1'b1;

  // ---------------- stimulus ----------------
  initial begin
    int unsigned c0;
    int base;

    rst_n = 1'b0;
    f_start = 0; b_start = 0; q_start = 0; r_start = 0;
    f_ready = 0; b_ready = 0; q_ready = 0; r_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, f_valid}, 32'd0);
    chk("rst_data", {13'b0, f_data}, 32'd0);
    chk("rst_count", {17'b0, f_count}, 32'd0);
    chk("rst_busy_done", {30'b0, f_busy, f_done}, 32'd0);
    chk("rst_alu", {18'b0, f_s, f_m, f_ci, f_a, f_b}, 32'd0);
    rst_n = 1'b1;

    // --- reset mid-sweep ---
    for (int i = 0; i < 16384; i++) f_q.push_back(exp_vec(14'(i)));
    f_ready = 1'b1;
    @(posedge clk); #1 f_start = 1'b1;
    @(posedge clk); #1 f_start = 1'b0;
    for (int k = 0; k < 100 && f_count != 15'd5; k++) @(negedge clk);
    chk("mid_count5", {17'b0, f_count}, 32'd5);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("mid_rst_valid", {31'b0, f_valid}, 32'd0);
    chk("mid_rst_data", {13'b0, f_data}, 32'd0);
    chk("mid_rst_count", {17'b0, f_count}, 32'd0);
    chk("mid_rst_busy_done", {30'b0, f_busy, f_done}, 32'd0);
    chk("mid_rst_alu", {18'b0, f_s, f_m, f_ci, f_a, f_b}, 32'd0);
    f_q.delete();
    @(negedge clk);

    // --- full sweep, ready held high ---
    for (int i = 0; i < 16384; i++) f_q.push_back(exp_vec(14'(i)));
    base = f_x;
    @(posedge clk); #1 f_start = 1'b1;
    @(posedge clk); #1 f_start = 1'b0;
    c0 = cyc;
    chk("start_busy", {31'b0, f_busy}, 32'd1);
    chk("start_alu0", {18'b0, f_s, f_m, f_ci, f_a, f_b}, 32'd0);
    chk("start_count0", {17'b0, f_count}, 32'd0);
    for (int k = 0; k < 10 && !f_valid; k++) @(negedge clk);
    chk("first_vec", {13'b0, f_data}, {13'b0, 1'b0, 14'h0, alu_ref(14'h0)});
    for (int k = 0; k < 40000 && !(f_valid && f_count == 15'd16383); k++) @(negedge clk);
    chk("last_vec_idx", {18'b0, f_data[17:4]}, 32'h3FFF);
    chk("last_not_done", {31'b0, f_done}, 32'd0);
    @(negedge clk);
    chk("done_after_last", {31'b0, f_done}, 32'd1);
    chk("sweep_cycles", cyc - c0, 32'd32768);
    chk("f_xfers", f_x - base, 32'd16384);
    chk("f_count_full", {17'b0, f_count}, 32'd16384);
    chk("f_q_empty", f_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("f_no_wrap", {18'b0, f_s, f_m, f_ci, f_a, f_b}, 32'h3FFF);

    // --- random backpressure, SETTLE=3 with delayed ALU ---
    for (int i = 0; i < 64; i++) b_q.push_back(exp_vec(14'(i)));
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int k = 0; k < 5000 && !b_done; k++) begin
      b_ready = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    b_ready = 1'b0;
    chk("b_done", {31'b0, b_done}, 32'd1);
    chk("b_xfers", b_x, 32'd64);
    chk("b_count", {17'b0, b_count}, 32'd64);
    chk("b_q_empty", b_q.size(), 32'd0);

    // --- SETTLE=1 against the delayed ALU must sample stale results ---
    q_ready = 1'b1;
    @(posedge clk); #1 q_start = 1'b1;
    @(posedge clk); #1 q_start = 1'b0;
    for (int k = 0; k < 500 && !q_done; k++) @(negedge clk);
    chk("q_xfers", q_x, 32'd64);
    chk("q_mismatch_seen", {31'b0, q_mis > 0}, 32'd1);

    // --- ignored start during EMIT, then restart from DONE ---
    for (int i = 0; i < 4; i++) r_q.push_back(exp_vec(14'(i)));
    @(posedge clk); #1 r_start = 1'b1;
    @(posedge clk); #1 r_start = 1'b0;
    for (int k = 0; k < 10 && !r_valid; k++) @(posedge clk);
    #1 r_start = 1'b1;
    @(posedge clk); #1 r_start = 1'b0;
    @(posedge clk); #1;
    chk("emit_start_valid", {31'b0, r_valid}, 32'd1);
    chk("emit_start_busy", {30'b0, r_busy, r_done}, 32'd2);
    chk("emit_start_alu", {18'b0, r_s, r_m, r_ci, r_a, r_b}, 32'd0);
    chk("emit_start_count", {17'b0, r_count}, 32'd0);
    r_ready = 1'b1;
    for (int k = 0; k < 50 && !r_done; k++) @(negedge clk);
    chk("r_done1", {31'b0, r_done}, 32'd1);
    chk("r_count1", {17'b0, r_count}, 32'd4);
    chk("r_xfers1", r_x, 32'd4);
    chk("r_hold_alu", {18'b0, r_s, r_m, r_ci, r_a, r_b}, 32'd3);
    for (int i = 0; i < 4; i++) r_q.push_back(exp_vec(14'(i)));
    @(posedge clk); #1 r_start = 1'b1;
    @(posedge clk); #1 r_start = 1'b0;
    chk("restart_count0", {17'b0, r_count}, 32'd0);
    chk("restart_state", {30'b0, r_busy, r_done}, 32'd2);
    for (int k = 0; k < 50 && !r_done; k++) @(negedge clk);
    chk("r_done2", {31'b0, r_done}, 32'd1);
    chk("r_count2", {17'b0, r_count}, 32'd4);
    chk("r_xfers2", r_x, 32'd8);
    chk("r_q_empty", r_q.size(), 32'd0);

    chk("busy_done_exclusive", {31'b0, bd_bad}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
